servo_pwm_out: RTL
==================

Name: servo_pwm_out

Overview:
- Downstream stage of the per-axis servo threshold generator.
- Converts the 15-bit pulse-width command (µs, nominally 800..2300) into a fixed-period RC-servo PWM waveform on the FPGA pin.
- The command is produced asynchronously on vsync. This block resynchronises it, clamps it, optionally slew-limits it, and applies it only at period boundaries so no pulse is ever truncated or stretched.

Parameters:
- TICK_DIV, 100, clk cycles per 1 µs tick (100 MHz clk).
- PERIOD_US, 20000, PWM period in µs (50 Hz).
- MIN_US, 800, lowest legal pulse width in µs.
- MAX_US, 2300, highest legal pulse width in µs.
- INIT_US, 1500, pulse width after reset (servo centre).
- SLEW_US, 40, maximum change of applied width per period in µs (used only with SERVO_SLEW_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run request; low parks the output low.
- thres_in  input  15  requested pulse width in µs, from the vsync-domain threshold generator.
- pwm_out  output  1  servo PWM pin, registered.
- period_start  output  1  one-clk pulse on the first clk of each period.
- active_thres  output  15  width in µs applied in the current period.
- running  output  1  high while in RUN.

Behaviour:
- Reset (async, rst_n=0):
  - pwm_out=0, period_start=0, running=0, active_thres=INIT_US.
  - Sync stages and target cleared to INIT_US; prescaler=0, us_cnt=0; state IDLE.
- Input capture:
  - thres_in passes through two flops, s1 then s2.
  - target <= clamp(s2) only on clks where s1==s2 (bus-coherency guard against vsync-domain updates). Otherwise target holds.
  - clamp: value < MIN_US -> MIN_US; value > MAX_US -> MAX_US; else unchanged.
- Tick: prescaler counts 0..TICK_DIV-1 and wraps. tick=1 on the wrap clk. Prescaler runs only in RUN and is held 0 in IDLE.
- us_cnt counts 0..PERIOD_US-1 on each tick, wrapping to 0.
- State IDLE:
  - pwm_out=0, running=0.
  - If enable=1: next clk enter RUN with prescaler=0, us_cnt=0.
  - On that entry clk: load active_thres, pulse period_start, set pwm_out=1.
- State RUN:
  - Period boundary = entry clk, or the clk where tick=1 and us_cnt wraps PERIOD_US-1 -> 0.
  - At boundary: active_thres <= next_width (see feature); period_start=1 for that clk only.
  - pwm_out registered as 1 while us_cnt < active_thres, else 0.
  - pulse high time = active_thres*TICK_DIV clks exactly; period = PERIOD_US*TICK_DIV clks exactly.
- enable dropped in RUN:
  - Current period completes.
  - At the next boundary, go to IDLE instead of reloading: pwm_out=0, no period_start.
  - enable re-raised before that boundary: no effect, RUN continues.
- target changes mid-period: ignored until the next boundary; active_thres is constant within a period.
- Simultaneous target update and boundary on the same clk: the boundary uses the target value from before that clk.
- Widths: us_cnt 15 bits; prescaler ceil(log2(TICK_DIV)) bits. Compare is unsigned 15-bit.
- MAX_US < PERIOD_US is required; pwm_out therefore always has a low phase.

Optional Feature:
- SERVO_SLEW_EN defined:
  - next_width = active_thres moved toward target by at most SLEW_US: if |target-active_thres| <= SLEW_US then target, else active_thres ± SLEW_US.
  - Arithmetic in 16-bit signed; result is never outside MIN_US..MAX_US.
- SERVO_SLEW_EN undefined: next_width = target; slew logic is not built.

Test Plan:
- Sim parameters: TICK_DIV=4, PERIOD_US=3000, SLEW_US=40.
1. Reset, enable=1, thres_in=1500 -> first period_start 1 clk after enable sampled; pwm_out high exactly 6000 clks, period 12000 clks; active_thres=1500.
2. thres_in=500 then 2900 -> active_thres=800, then 2300 (slew off); high times 3200 and 9200 clks.
3. thres_in 1500 -> 2000 changed at us_cnt=1000 mid-pulse -> current pulse stays 6000 clks; next period uses 2000 (slew off); with SERVO_SLEW_EN successive widths 1540, 1580, 1620...
4. enable dropped at us_cnt=100 -> current period finishes normally; pwm_out stays 0 afterwards; running=0 and no period_start after that boundary.
5. rst_n pulsed low at us_cnt=200 while pwm_out=1 -> pwm_out=0 immediately, active_thres=1500; after release, a new period starts with full 1500 µs pulse.
6. thres_in toggled between 1000 and 2000 every clk for 50 clks, then held at 1800 -> target never takes a value other than 1000, 2000 or 1800; next boundary applies 1800 (slew off).

Source files
------------

// File: rtl/servo_pwm_out.sv
// Fixed-period RC-servo PWM generator: resynchronises, clamps and applies the width command at period boundaries.
// Optional per-period slew limiting is built when SERVO_SLEW_EN is defined.
module servo_pwm_out #(
    parameter int TICK_DIV  = 100,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 800,
    parameter int MAX_US    = 2300,
    parameter int INIT_US   = 1500,
    parameter int SLEW_US   = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [14:0] thres_in,
    output logic        pwm_out,
    output logic        period_start,
    output logic [14:0] active_thres,
    output logic        running
);
    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [14:0]   US_LAST  = 15'(PERIOD_US - 1);
    localparam logic [14:0]   MIN_W    = 15'(MIN_US);
    localparam logic [14:0]   MAX_W    = 15'(MAX_US);
    localparam logic [14:0]   INIT_W   = 15'(INIT_US);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [14:0]   s1_q, s2_q;
    logic [14:0]   target_q, target_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [14:0]   us_q, us_d;
    logic [14:0]   act_q, act_d;
    logic          pwm_q, pwm_d;
    logic          ps_q, ps_d;
    logic          tick_s;
    logic [14:0]   next_width_s;

    function automatic logic [14:0] clamp_width(input logic [14:0] v);
        logic [14:0] r;
        if (v < MIN_W) begin
            r = MIN_W;
        end else if (v > MAX_W) begin
            r = MAX_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Result always lies between cur and tgt, so it stays inside the clamped range.
    function automatic logic [14:0] slew_step(input logic [14:0] cur, input logic [14:0] tgt);
        logic signed [15:0] diff;
        logic signed [15:0] step;
        logic signed [15:0] res;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        step = $signed(16'(SLEW_US));
        if (diff > step) begin
            res = $signed({1'b0, cur}) + step;
        end else if (diff < -step) begin
            res = $signed({1'b0, cur}) - step;
        end else begin
            res = $signed({1'b0, tgt});
        end
        return res[14:0];
    endfunction

`ifdef SERVO_SLEW_EN
    assign next_width_s = slew_step(act_q, target_q);
`else
    assign next_width_s = target_q;
`endif

    // Target only follows the synchroniser when both stages agree, filtering mid-update bus values.
    always_comb begin
        target_d = target_q;
        if (s1_q == s2_q) begin
            target_d = clamp_width(s2_q);
        end else begin
            target_d = target_q;
        end
    end

    // Two-flop resynchroniser and coherent target register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= INIT_W;
            s2_q     <= INIT_W;
            target_q <= INIT_W;
        end else begin
            s1_q     <= thres_in;
            s2_q     <= s1_q;
            target_q <= target_d;
        end
    end

    // Next-state, counters and registered outputs; width is reloaded only at period boundaries.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        us_d    = us_q;
        act_d   = act_q;
        pwm_d   = 1'b0;
        ps_d    = 1'b0;
        tick_s  = (state_q == RUN) && (pre_q == PRE_LAST);
        case (state_q)
            IDLE: begin
                pre_d = '0;
                us_d  = '0;
                if (enable) begin
                    state_d = RUN;
                    act_d   = next_width_s;
                    ps_d    = 1'b1;
                    pwm_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                pre_d = tick_s ? '0 : pre_q + PW'(1);
                if (tick_s && (us_q == US_LAST)) begin
                    us_d = '0;
                    if (enable) begin
                        act_d = next_width_s;
                        ps_d  = 1'b1;
                        pwm_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        pwm_d   = 1'b0;
                    end
                end else begin
                    us_d  = tick_s ? us_q + 15'd1 : us_q;
                    pwm_d = (us_d < act_q);
                end
            end
            default: begin
                state_d = IDLE;
                pre_d   = '0;
                us_d    = '0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            us_q    <= 15'd0;
            act_q   <= INIT_W;
            pwm_q   <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            us_q    <= us_d;
            act_q   <= act_d;
            pwm_q   <= pwm_d;
            ps_q    <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign active_thres = act_q;
    assign running      = (state_q == RUN);

endmodule
